// File: rtl/sensor_sequencer_if.sv
// sensor_sequencer_if: control-register, sensor handshake and write-back signals of the sequencer
interface sensor_sequencer_if;
   logic [31:0] ctrl_in;
   logic        sensor_start;
   logic        sensor_done;
   logic [15:0] sensor_data;
   logic        wr2;
   logic [31:0] wr2_data;
   logic        busy;
   modport master (input ctrl_in, sensor_done, sensor_data, output sensor_start, wr2, wr2_data, busy);
   modport slave (output ctrl_in, sensor_done, sensor_data, input sensor_start, wr2, wr2_data, busy);
endinterface

// File: rtl/sensor_sequencer.sv
// sensor_sequencer: runs one sensor transaction per SEND and writes the result back through WR2.
// Define SENSOR_TIMEOUT_EN to abort a WAIT after TIMEOUT_CYCLES cycles with err=1.
module sensor_sequencer #(
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input logic clk,
   input logic rst,
   sensor_sequencer_if.master bus
);
   typedef enum logic [2:0] {IDLE, START, WAIT, WRBACK, HOLD} state_e;
   state_e state_q, state_d;
   logic [15:0] result_q, result_d;
   logic start_q, wr2_q, busy_q;
   logic timeout, err_q;
   logic unused;
`ifdef SENSOR_TIMEOUT_EN
   logic [23:0] cnt_q, cnt_d;
   logic err_d;
   // sensor_done on the final count wins over the abort
   assign timeout = state_q == WAIT && !bus.sensor_done && cnt_q + 24'd1 == 24'(TIMEOUT_CYCLES);
   always_comb begin
      cnt_d = state_q == WAIT ? cnt_q + 24'd1 : '0;
      err_d = (state_q == WAIT && (timeout || bus.sensor_done)) ? timeout : err_q;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end
`else
   assign timeout = 1'b0;
   assign err_q = 1'b0;
`endif
   always_comb begin
      state_d = state_q;
      result_d = result_q;
      case (state_q)
         IDLE: state_d = bus.ctrl_in[0] ? START : IDLE;
         START: state_d = WAIT;
         WAIT: begin
            if (bus.sensor_done) begin
               state_d = WRBACK;
               result_d = bus.sensor_data;
            end else if (timeout) begin
               state_d = WRBACK;
               result_d = '0;
            end
         end
         WRBACK: state_d = HOLD;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         result_q <= '0;
         start_q <= 1'b0;
         wr2_q <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         state_q <= state_d;
         result_q <= result_d;
         start_q <= state_d == START;
         wr2_q <= state_d == WRBACK;
         busy_q <= state_d != IDLE;
      end
   end
   // config bits come from the live register so CPU edits during WAIT survive
   assign bus.wr2_data = wr2_q ? {result_q, bus.ctrl_in[15:2], err_q, 1'b0} : '0;
   assign bus.sensor_start = start_q;
   assign bus.wr2 = wr2_q;
   assign bus.busy = busy_q;
   assign unused = ^{bus.ctrl_in[31:16], bus.ctrl_in[1], 32'(TIMEOUT_CYCLES)};
endmodule

// File: tb/tb_sensor_sequencer.sv
// tb_sensor_sequencer: transaction-schedule model of the sequencer plus directed and random stimulus.
module tb_sensor_sequencer;
   localparam int TO = 8;
   logic clk = 1'b0;
   logic rst = 1'b1;
   sensor_sequencer_if bus ();
   sensor_sequencer #(.TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rst(rst), .bus(bus.master));
   always #5 clk = ~clk;
   int vectors = 0, errors = 0;
   int cyc = 0, m_st = 0, m_wr = -1, wb_cyc = -10;
   bit m_txn = 0, m_err = 0;
   logic [15:0] m_res = '0;
   logic [31:0] wb_data = '0, last_data = '0;
   int n_start = 0, n_wr = 0, n_busy = 0, start_at = 0, start_gap = 0;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask
   always @(posedge rst) m_txn = 0;
   // Model: a transaction is a start cycle, then WAIT until done (or timeout), then WRBACK and HOLD
   always @(posedge clk) begin
      logic e_start, e_wr, e_busy;
      logic [31:0] e_data;
      if (!rst) begin
         cyc++;
         if (m_txn) begin
            if (m_wr < 0 && cyc - 1 > m_st) begin
               if (bus.sensor_done) begin
                  m_wr = cyc;
                  m_res = bus.sensor_data;
                  m_err = 0;
               end
`ifdef SENSOR_TIMEOUT_EN
               else if (cyc - 1 - m_st == TO) begin
                  m_wr = cyc;
                  m_res = '0;
                  m_err = 1;
               end
`endif
            end else if (m_wr >= 0 && cyc == m_wr + 2) m_txn = 0;
         end else if (bus.ctrl_in[0]) begin
            m_txn = 1;
            m_st = cyc;
            m_wr = -1;
         end
      end
      #1;
      e_start = m_txn && cyc == m_st;
      e_wr = m_txn && cyc == m_wr;
      e_busy = m_txn;
      e_data = e_wr ? {m_res, bus.ctrl_in[15:2], m_err, 1'b0} : 32'h0;
      chk("sensor_start", {31'h0, bus.sensor_start}, {31'h0, e_start});
      chk("wr2", {31'h0, bus.wr2}, {31'h0, e_wr});
      chk("busy", {31'h0, bus.busy}, {31'h0, e_busy});
      chk("wr2_data", bus.wr2_data, e_data);
      if (e_wr) begin
         wb_data = e_data;
         wb_cyc = cyc;
      end
      if (bus.sensor_start) begin
         start_gap = cyc - start_at;
         start_at = cyc;
      end
      n_start += int'(bus.sensor_start);
      n_wr += int'(bus.wr2);
      n_busy += int'(bus.busy);
      if (bus.wr2) last_data = bus.wr2_data;
   end
   // Each step lands mid-cycle; the register takes the WR2 write during HOLD
   task automatic step();
      @(negedge clk);
      bus.sensor_done = 1'b0;
      if (cyc == wb_cyc + 1) bus.ctrl_in = wb_data;
   endtask
   task automatic clr();
      n_start = 0;
      n_wr = 0;
      n_busy = 0;
      last_data = '0;
   endtask
   initial begin
      bus.ctrl_in = '0;
      bus.sensor_done = 1'b0;
      bus.sensor_data = '0;
      repeat (2) @(negedge clk);
      chk("reset_busy", {31'h0, bus.busy}, 32'h0);
      chk("reset_wr2_data", bus.wr2_data, 32'h0);
      rst = 1'b0;
      step();
      clr();
      bus.ctrl_in = 32'h0000_0001;
      repeat (5) step();
      bus.sensor_done = 1'b1;
      bus.sensor_data = 16'h1234;
      repeat (4) step();
      chk("basic_starts", n_start, 1);
      chk("basic_writes", n_wr, 1);
      chk("basic_data", last_data, 32'h1234_0000);
      chk("basic_busy_cycles", n_busy, 7);
      clr();
      bus.ctrl_in = 32'h0000_A5F1;
      repeat (2) step();
      bus.ctrl_in = 32'h0000_0F01;
      step();
      bus.sensor_done = 1'b1;
      bus.sensor_data = 16'hBEEF;
      repeat (4) step();
      chk("cfg_edit_data", last_data, 32'hBEEF_0F00);
      clr();
      bus.ctrl_in = 32'h0000_0001;
`ifdef SENSOR_TIMEOUT_EN
      repeat (16) step();
      chk("timeout_data", last_data, 32'h0000_0002);
      chk("timeout_writes", n_wr, 1);
      chk("timeout_busy_cycles", n_busy, 11);
`else
      repeat (1001) step();
      chk("hang_writes", n_wr, 0);
      chk("hang_busy", {31'h0, bus.busy}, 32'h1);
      chk("hang_busy_1000", {31'h0, n_busy >= 1000}, 32'h1);
      bus.sensor_done = 1'b1;
      repeat (4) step();
`endif
      clr();
      bus.ctrl_in = 32'h0000_0001;
      repeat (9) step();
      bus.sensor_done = 1'b1;
      bus.sensor_data = 16'h0042;
      repeat (4) step();
      chk("edge_done_data", last_data, 32'h0042_0000);
      clr();
      bus.ctrl_in = 32'h0000_0001;
      repeat (4) step();
      #2 rst = 1'b1;
      bus.ctrl_in = '0;
      #1;
      chk("async_busy", {31'h0, bus.busy}, 32'h0);
      chk("async_wr2", {31'h0, bus.wr2}, 32'h0);
      chk("async_start", {31'h0, bus.sensor_start}, 32'h0);
      #1 rst = 1'b0;
      step();
      bus.sensor_done = 1'b1;
      bus.sensor_data = 16'h7777;
      repeat (4) step();
      chk("post_reset_writes", n_wr, 0);
      chk("post_reset_busy", {31'h0, bus.busy}, 32'h0);
      clr();
      bus.ctrl_in = 32'h0000_0001;
      repeat (2) step();
      bus.sensor_done = 1'b1;
      bus.sensor_data = 16'h0101;
      repeat (2) step();
      bus.ctrl_in[0] = 1'b1;
      step();
      bus.sensor_done = 1'b1;
      bus.sensor_data = 16'hDEAD;
      repeat (2) step();
      bus.sensor_done = 1'b1;
      bus.sensor_data = 16'h0202;
      repeat (4) step();
      chk("resend_starts", n_start, 2);
      chk("resend_gap", start_gap, 5);
      chk("resend_writes", n_wr, 2);
      chk("resend_data", last_data, 32'h0202_0000);
      for (int i = 0; i < 3000; i++) begin
         step();
         if ($urandom_range(7) == 0) bus.ctrl_in[0] = 1'b1;
         if ($urandom_range(4) == 0) bus.ctrl_in[15:2] = 14'($urandom);
         if ($urandom_range(4) == 0) begin
            bus.sensor_done = 1'b1;
            bus.sensor_data = 16'($urandom);
         end
         if ($urandom_range(399) == 0) begin
            #2 rst = 1'b1;
            #2 rst = 1'b0;
         end
      end
      repeat (20) step();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
